// File: rtl/data_pipe_arb_pkg.sv
// Shared types and helpers for the data_pipe round-robin arbiter.
// No logic, so no latency.
// No flow control of its own.
package data_pipe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } ARB_STATE;

  // Select width that stays at least one bit wide when only one requester exists
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_pipe_rr_pick.sv
// Rotate-priority encoder: first unmasked request at or after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module data_pipe_rr_pick
  import data_pipe_arb_pkg::*;
#(
  parameter int NUM = 8,
  localparam int NSIZE = clog2_min1(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] ptr,
  input  logic [NUM-1:0]   mask,
  output logic [NSIZE-1:0] idx,
  output logic             any
);

  logic [NUM-1:0]   eff;
  logic [NSIZE-1:0] k;

  assign eff = req & ~mask;

  // Walk ptr, ptr+1, ... NUM-1, 0, ... ptr-1 and keep the first hit
  always_comb begin
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < NUM; i++) begin
      k = NSIZE'((int'(ptr) + i) % NUM);
      if (!any && eff[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/data_pipe_rr_arbiter.sv
// Packet-locked round-robin arbiter driving the interconnect path select.
// Request seen in IDLE -> addr next cycle, grant the cycle after; one dead cycle between owners.
// Grant holds while the owner stalls (valid or ready low); release only on last or beat budget.
module data_pipe_rr_arbiter
  import data_pipe_arb_pkg::*;
#(
  parameter int NUM       = 8,
  parameter int MAX_BEATS = 0,
  parameter int CSIZE     = 16,
  localparam int NSIZE    = clog2_min1(NUM)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [NUM-1:0]   up_valid,
  input  logic [NUM-1:0]   up_ready,
  input  logic [NUM-1:0]   up_last,
  output logic [NSIZE-1:0] addr,
  output logic [NUM-1:0]   grant,
  output logic             busy,
  output logic [CSIZE-1:0] beat_cnt
);

  localparam logic [CSIZE-1:0] BUD_LAST = (MAX_BEATS == 0) ? '0 : CSIZE'(MAX_BEATS - 1);

  ARB_STATE         state, state_n;
  logic [NSIZE-1:0] ptr, ptr_n, ptr_rel;
  logic [NSIZE-1:0] addr_n;
  logic [NUM-1:0]   grant_n;
  logic [CSIZE-1:0] cnt_n;
  logic             busy_n;

  logic             xfer, end_pkt, end_bud, release_c;
  logic [NSIZE-1:0] pk_ptr, pk_idx;
  logic             pk_any;

  // Owner handshake and release conditions; only meaningful while granted
  assign xfer      = (state == GRANT) && up_valid[addr] && up_ready[addr] && clk_en;
  assign end_pkt   = xfer && up_last[addr];
  assign end_bud   = xfer && (MAX_BEATS != 0) && (beat_cnt == BUD_LAST);
  assign release_c = end_pkt || end_bud;

  // Pointer one past the current owner, wrapping at NUM
  assign ptr_rel = (addr == NSIZE'(NUM - 1)) ? '0 : addr + NSIZE'(1);

  // At release arbitrate from the post-release pointer; grant is one-hot on the
  // owner in GRANT and zero elsewhere, so it doubles as the owner mask
  assign pk_ptr = (state == GRANT) ? ptr_rel : ptr;

  data_pipe_rr_pick #(.NUM(NUM)) u_pick (
    .req  (up_valid),
    .ptr  (pk_ptr),
    .mask (grant),
    .idx  (pk_idx),
    .any  (pk_any)
  );

  // Next-state and next-output decode; every update is gated by clk_en
  always_comb begin
    state_n = state;
    addr_n  = addr;
    grant_n = grant;
    cnt_n   = beat_cnt;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (clk_en && pk_any) begin
          addr_n  = pk_idx;
          state_n = SWITCH;
        end
      end
      SWITCH: begin
        if (clk_en) begin
          grant_n = NUM'(1) << addr;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (xfer && (beat_cnt != '1)) cnt_n = beat_cnt + CSIZE'(1);
        if (release_c) begin
          ptr_n   = ptr_rel;
          grant_n = '0;
          if (pk_any) begin
            addr_n  = pk_idx;
            state_n = SWITCH;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, pointer and registered outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      addr     <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      addr     <= addr_n;
      grant    <= grant_n;
      busy     <= busy_n;
      beat_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_data_pipe_rr_arbiter.sv
// Directed bench for data_pipe_rr_arbiter: unlimited-budget and 4-beat-budget instances.
// Outputs sampled 1ns after each rising edge, inputs driven at the same point.
// Fixed cycle counts throughout plus a global time limit.
module tb_data_pipe_rr_arbiter;

  logic        clock, rst, clk_en;
  logic [7:0]  valid, ready, last;
  logic [2:0]  addr;
  logic [7:0]  grant;
  logic        busy;
  logic [15:0] cnt;
  logic [7:0]  valid4, ready4, last4;
  logic [2:0]  addr4;
  logic [7:0]  grant4;
  logic        busy4;
  logic [15:0] cnt4;

  int checks   = 0;
  int failures = 0;

  data_pipe_rr_arbiter #(.NUM(8), .MAX_BEATS(0), .CSIZE(16)) dut (
    .clock(clock), .rst(rst), .clk_en(clk_en),
    .up_valid(valid), .up_ready(ready), .up_last(last),
    .addr(addr), .grant(grant), .busy(busy), .beat_cnt(cnt)
  );

  data_pipe_rr_arbiter #(.NUM(8), .MAX_BEATS(4), .CSIZE(16)) dut4 (
    .clock(clock), .rst(rst), .clk_en(clk_en),
    .up_valid(valid4), .up_ready(ready4), .up_last(last4),
    .addr(addr4), .grant(grant4), .busy(busy4), .beat_cnt(cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    valid = 8'h00; last = 8'h00; ready = 8'hff;
    valid4 = 8'h00; last4 = 8'h00; ready4 = 8'hff;
    clk_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1;
    valid = 8'h00; last = 8'h00; ready = 8'h00;
    valid4 = 8'h00; last4 = 8'h00; ready4 = 8'h00;
    #3;
    checks++; if (addr !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", addr); end
    checks++; if (grant !== 8'h00) begin failures++; $display("FAIL reset_grant got=%0h exp=0", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", cnt); end
    checks++; if (grant4 !== 8'h00 || busy4 !== 1'b0) begin failures++; $display("FAIL reset_dut4 got=%0h/%0h exp=0/0", grant4, busy4); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req busy got=%0h exp=0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    valid = 8'h04; ready = 8'hff; last = 8'h00;
    tick();
    checks++; if (addr !== 3'd2) begin failures++; $display("FAIL single_addr got=%0h exp=2", addr); end
    checks++; if (grant !== 8'h00 || busy !== 1'b1) begin failures++; $display("FAIL single_switch grant/busy got=%0h/%0h exp=0/1", grant, busy); end
    tick();
    checks++; if (grant !== 8'h04) begin failures++; $display("FAIL single_grant got=%0h exp=04", grant); end
    checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL single_cnt0 got=%0d exp=0", cnt); end
    tick();
    tick();
    checks++; if (cnt !== 16'd2 || grant !== 8'h04) begin failures++; $display("FAIL single_mid cnt/grant got=%0d/%0h exp=2/04", cnt, grant); end
    last = 8'h04;
    tick();
    checks++; if (grant !== 8'h00) begin failures++; $display("FAIL single_release_grant got=%0h exp=0", grant); end
    checks++; if (cnt !== 16'd3) begin failures++; $display("FAIL single_beats got=%0d exp=3", cnt); end
    checks++; if (busy !== 1'b0 || addr !== 3'd2) begin failures++; $display("FAIL single_idle busy/addr got=%0h/%0h exp=0/2", busy, addr); end
    valid = 8'h00; last = 8'h00;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_stays_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_all_rr();
    logic [7:0] eg;
    logic [2:0] ea;
    do_reset();
    valid = 8'hff; last = 8'hff; ready = 8'hff;
    tick();
    checks++; if (addr !== 3'd0) begin failures++; $display("FAIL rr_first_addr got=%0h exp=0", addr); end
    for (int k = 0; k < 9; k++) begin
      eg = 8'h01 << (k % 8);
      ea = 3'((k + 1) % 8);
      tick();
      checks++; if (grant !== eg) begin failures++; $display("FAIL rr_grant[%0d] got=%0h exp=%0h", k, grant, eg); end
      tick();
      checks++; if (grant !== 8'h00 || addr !== ea || busy !== 1'b1) begin failures++; $display("FAIL rr_dead[%0d] grant/addr/busy got=%0h/%0h/%0h exp=0/%0h/1", k, grant, addr, busy, ea); end
    end
  endtask

  task automatic test_budget();
    int own[6];
    int len[6];
    int rem[8];
    own[0] = 1; own[1] = 5; own[2] = 1; own[3] = 5; own[4] = 1; own[5] = 5;
    len[0] = 4; len[1] = 4; len[2] = 4; len[3] = 4; len[4] = 2; len[5] = 2;
    for (int i = 0; i < 8; i++) rem[i] = 0;
    rem[1] = 10; rem[5] = 10;
    do_reset();
    valid4 = 8'h22; ready4 = 8'hff; last4 = 8'h00;
    tick();
    checks++; if (addr4 !== 3'd1) begin failures++; $display("FAIL bud_first_addr got=%0h exp=1", addr4); end
    for (int s = 0; s < 6; s++) begin
      tick();
      checks++; if (grant4 !== (8'h01 << own[s])) begin failures++; $display("FAIL bud_owner[%0d] got=%0h exp=%0h", s, grant4, 8'h01 << own[s]); end
      checks++; if (cnt4 !== 16'd0) begin failures++; $display("FAIL bud_cnt_reset[%0d] got=%0d exp=0", s, cnt4); end
      for (int b = 0; b < len[s]; b++) begin
        last4 = (rem[own[s]] == 1) ? (8'h01 << own[s]) : 8'h00;
        tick();
        rem[own[s]]--;
        checks++; if (cnt4 !== 16'(b + 1)) begin failures++; $display("FAIL bud_cnt[%0d.%0d] got=%0d exp=%0d", s, b, cnt4, b + 1); end
      end
      checks++; if (grant4 !== 8'h00) begin failures++; $display("FAIL bud_release[%0d] got=%0h exp=0", s, grant4); end
      if (rem[own[s]] == 0) valid4[own[s]] = 1'b0;
      last4 = 8'h00;
      if (s < 5) begin
        checks++; if (addr4 !== 3'(own[s + 1]) || busy4 !== 1'b1) begin failures++; $display("FAIL bud_next_addr[%0d] got=%0h/%0h exp=%0h/1", s, addr4, busy4, own[s + 1]); end
      end
    end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL bud_end_idle got=%0h exp=0", busy4); end
  endtask

  task automatic test_hold();
    do_reset();
    valid = 8'h08; ready = 8'hff; last = 8'h00;
    tick();
    valid = 8'h48;
    tick();
    checks++; if (grant !== 8'h08) begin failures++; $display("FAIL hold_grant got=%0h exp=08", grant); end
    tick();
    valid = 8'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (grant !== 8'h08 || cnt !== 16'd1) begin failures++; $display("FAIL hold_gap[%0d] grant/cnt got=%0h/%0d exp=08/1", i, grant, cnt); end
    end
    valid = 8'h48;
    tick();
    checks++; if (cnt !== 16'd2) begin failures++; $display("FAIL hold_resume_cnt got=%0d exp=2", cnt); end
    last = 8'h08;
    tick();
    checks++; if (grant !== 8'h00 || addr !== 3'd6) begin failures++; $display("FAIL hold_release grant/addr got=%0h/%0h exp=0/6", grant, addr); end
    valid = 8'h40; last = 8'h00;
    tick();
    checks++; if (grant !== 8'h40) begin failures++; $display("FAIL hold_next_owner got=%0h exp=40", grant); end
    last = 8'h40;
    tick();
    valid = 8'h00; last = 8'h00;
    checks++; if (grant !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL hold_done grant/busy got=%0h/%0h exp=0/0", grant, busy); end
  endtask

  task automatic test_clk_en();
    logic        en[12];
    int          ecnt[12];
    logic [7:0]  egr[12];
    logic        ebusy[12];
    en    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ecnt  = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4};
    egr   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    ebusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    valid = 8'h01; ready = 8'hff; last = 8'h00;
    for (int i = 0; i < 12; i++) begin
      clk_en = en[i];
      last   = (i >= 10) ? 8'h01 : 8'h00;
      tick();
      checks++; if (cnt !== 16'(ecnt[i]) || grant !== egr[i] || busy !== ebusy[i]) begin failures++; $display("FAIL clk_en[%0d] cnt/grant/busy got=%0d/%0h/%0h exp=%0d/%0h/%0h", i, cnt, grant, busy, ecnt[i], egr[i], ebusy[i]); end
    end
    valid = 8'h00; last = 8'h00; clk_en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    valid = 8'h80; ready = 8'hff; last = 8'h00;
    tick();
    tick();
    checks++; if (grant !== 8'h80) begin failures++; $display("FAIL arst_pre_grant got=%0h exp=80", grant); end
    tick();
    #2;
    rst = 1'b1;
    valid = 8'h84;
    #1;
    checks++; if (grant !== 8'h00 || addr !== 3'd0 || busy !== 1'b0 || cnt !== 16'd0) begin failures++; $display("FAIL arst_async grant/addr/busy/cnt got=%0h/%0h/%0h/%0d exp=0/0/0/0", grant, addr, busy, cnt); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (addr !== 3'd2 || busy !== 1'b1) begin failures++; $display("FAIL arst_first_winner addr/busy got=%0h/%0h exp=2/1", addr, busy); end
    tick();
    checks++; if (grant !== 8'h04) begin failures++; $display("FAIL arst_new_grant got=%0h exp=04", grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_budget();
    test_hold();
    test_clk_en();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
